// File: rtl/svm_cfg_loader_if.sv
// Load-stream channel feeding the SVM coefficient loader: valid/ready beats
// with a last-beat marker closing the model.
interface svm_cfg_loader_if #(
    parameter int BUS_W = 32
);
    logic             s_valid;
    logic             s_ready;
    logic [BUS_W-1:0] s_data;
    logic             s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/svm_cfg_loader.sv
// Streams an SVM model (bias beat, then N_WORDS coefficient words of BEATS
// beats each) into the coefficient RAM, with framing checks on s_last.
module svm_cfg_loader #(
    parameter int COEF_W  = 12,
    parameter int N_COEF  = 105,
    parameter int ADDR_W  = 6,
    parameter int N_WORDS = 36,
    parameter int BUS_W   = 32,
    localparam int RAM_DW = COEF_W * N_COEF,
    localparam int BEATS  = (RAM_DW + BUS_W - 1) / BUS_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    svm_cfg_loader_if.slave    s_bus,
    output logic [ADDR_W-1:0]  addr_a,
    output logic               write_en,
    output logic [RAM_DW-1:0]  i_data,
    output logic [COEF_W-1:0]  bias,
    output logic               b_load,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               det_en
);
    localparam int BEAT_W  = $clog2(BEATS);
    localparam int LAST_LO = (BEATS - 1) * BUS_W;
    localparam int LAST_W  = RAM_DW - LAST_LO;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BIAS  = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic              s_ready_q, s_ready_d;
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RAM_DW-1:0] idata_q, idata_d;
    logic [COEF_W-1:0] bias_q, bias_d;
    logic              b_load_q, b_load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              det_en_q, det_en_d;

    logic [BUS_W-1:0]   buf_q [BEATS-1];
    logic [LAST_LO-1:0] buf_flat;
    logic               hs, final_beat, frame_err, abort;

    assign hs         = s_bus.s_valid & s_ready_q;
    assign final_beat = (beat_q == LAST_BEAT) && (word_q == LAST_WORD);
    // s_last must appear exactly on the final beat of the final word
    assign frame_err  = s_bus.s_last ? !final_beat : final_beat;

    // The last beat is never buffered: it goes straight into the write word.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS - 1; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (state_q == S_FILL && hs && beat_q == BEAT_W'(gi))
                    buf_q[gi] <= s_bus.s_data;
            end
            assign buf_flat[gi*BUS_W +: BUS_W] = buf_q[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        word_d     = word_q;
        s_ready_d  = s_ready_q;
        write_en_d = 1'b0;
        addr_d     = addr_q;
        idata_d    = idata_q;
        bias_d     = bias_q;
        b_load_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        det_en_d   = det_en_q;
        abort      = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_BIAS;
                s_ready_d = 1'b1;
                busy_d    = 1'b1;
                done_d    = 1'b0;
                err_d     = 1'b0;
                det_en_d  = 1'b0;
            end
            S_BIAS: if (hs) begin
                if (s_bus.s_last) begin
                    abort = 1'b1;
                end else begin
                    bias_d   = s_bus.s_data[COEF_W-1:0];
                    b_load_d = 1'b1;
                    word_d   = '0;
                    beat_d   = '0;
                    state_d  = S_FILL;
                end
            end
            S_FILL: if (hs) begin
                if (frame_err) begin
                    abort = 1'b1;
                end else if (beat_q == LAST_BEAT) begin
                    state_d    = S_WRITE;
                    s_ready_d  = 1'b0;
                    write_en_d = 1'b1;
                    addr_d     = word_q;
                    idata_d    = {s_bus.s_data[LAST_W-1:0], buf_flat};
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (word_q == LAST_WORD) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    det_en_d = 1'b1;
                end else begin
                    word_d    = word_q + 1'b1;
                    beat_d    = '0;
                    s_ready_d = 1'b1;
                    state_d   = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            s_ready_d = 1'b0;
            busy_d    = 1'b0;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            word_q     <= '0;
            s_ready_q  <= 1'b0;
            write_en_q <= 1'b0;
            addr_q     <= '0;
            idata_q    <= '0;
            bias_q     <= '0;
            b_load_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            det_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            s_ready_q  <= s_ready_d;
            write_en_q <= write_en_d;
            addr_q     <= addr_d;
            idata_q    <= idata_d;
            bias_q     <= bias_d;
            b_load_q   <= b_load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            det_en_q   <= det_en_d;
        end
    end

    assign s_bus.s_ready = s_ready_q;
    assign write_en      = write_en_q;
    assign addr_a        = addr_q;
    assign i_data        = idata_q;
    assign bias          = bias_q;
    assign b_load        = b_load_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign det_en        = det_en_q;
endmodule

// File: tb/tb_svm_cfg_loader.sv
// Directed bench for svm_cfg_loader: full loads (continuous and gappy valid),
// framing errors, ignored start and mid-load reset.
module tb_svm_cfg_loader;
    localparam int RAM_DW  = 1260;
    localparam int BEATS   = 40;
    localparam int N_WORDS = 36;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [5:0]        addr_a;
    logic              write_en;
    logic [RAM_DW-1:0] i_data;
    logic [11:0]       bias;
    logic              b_load, busy, done, err, det_en;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int bl_cnt = 0;
    int last_addr = -1;
    int cyc = 0;
    int c0 = 0;

    svm_cfg_loader_if #(.BUS_W(32)) s_if ();

    svm_cfg_loader dut (
        .clk(clk), .rst(rst), .start(start), .s_bus(s_if),
        .addr_a(addr_a), .write_en(write_en), .i_data(i_data), .bias(bias),
        .b_load(b_load), .busy(busy), .done(done), .err(err), .det_en(det_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [RAM_DW-1:0] obs, input logic [RAM_DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Coefficient word w: beat k carries {w,k}; bits above RAM_DW are dropped.
    function automatic logic [RAM_DW-1:0] exp_word(input int w);
        logic [BEATS*32-1:0] t;
        for (int k = 0; k < BEATS; k++) t[k*32 +: 32] = {w[15:0], k[15:0]};
        return t[RAM_DW-1:0];
    endfunction

    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            chk("wr_addr", addr_a, wr_cnt);
            chk("wr_data", i_data, exp_word(wr_cnt));
            chk("wr_ready_low", s_if.s_ready, 0);
            last_addr = addr_a;
            wr_cnt++;
        end
        if (b_load === 1'b1) begin
            chk("bias_val", bias, 12'h0A5);
            bl_cnt++;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l, input bit rnd);
        bit got = 1'b0;
        bit hs;
        if (rnd) while ($urandom_range(1, 0) == 1) begin
            s_if.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        s_if.s_last  = l;
        for (int n = 0; n < 16 && !got; n++) begin
            hs = s_if.s_ready;
            @(posedge clk); #1;
            got = hs;
        end
        if (!got) chk("beat_accept", got, 1);
    endtask

    task automatic run_load(input bit rnd, input int err_w, input int err_b,
                            input bit omit_final, input int pulse_w, input int rst_w);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", err, 0);
        chk("start_det_clr", det_en, 0);
        send_beat(32'h0000_00A5, err_w == -1, rnd);
        if (err_w == -1) begin
            s_if.s_valid = 1'b0; s_if.s_last = 1'b0;
            return;
        end
        for (int w = 0; w < N_WORDS; w++) begin
            if (w == rst_w) begin
                s_if.s_valid = 1'b0; s_if.s_last = 1'b0;
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            for (int b = 0; b < BEATS; b++) begin
                bit fin;
                bit inj;
                fin = (w == N_WORDS - 1) && (b == BEATS - 1);
                inj = (w == err_w) && (b == err_b);
                if (w == pulse_w && b == 0) start = 1'b1;
                send_beat({w[15:0], b[15:0]}, fin ? !omit_final : inj, rnd);
                start = 1'b0;
                if (inj || (fin && omit_final)) begin
                    s_if.s_valid = 1'b0; s_if.s_last = 1'b0;
                    return;
                end
            end
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 64 && done !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_det_en"}, det_en, 0);
        chk({tag, "_s_ready"}, s_if.s_ready, 0);
        chk({tag, "_write_en"}, write_en, 0);
        chk({tag, "_b_load"}, b_load, 0);
        chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_bias"}, bias, 0);
        chk({tag, "_i_data"}, i_data, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1;
        s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_cleared("reset");
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        // Continuous load with timing check
        wr_cnt = 0; bl_cnt = 0;
        run_load(1'b0, -2, 0, 1'b0, -1, -1);
        wait_done();
        chk("l1_cycles", cyc - c0, 1477);
        chk("l1_done", done, 1);
        chk("l1_det_en", det_en, 1);
        chk("l1_err", err, 0);
        chk("l1_busy", busy, 0);
        chk("l1_writes", wr_cnt, 36);
        chk("l1_bloads", bl_cnt, 1);
        repeat (5) @(posedge clk);
        #1 chk("hold_addr", addr_a, 35);
        chk("hold_data", i_data, exp_word(35));
        $display("load continuous: writes %0d bias_loads %0d done %0b err %0b", wr_cnt, bl_cnt, done, err);

        // Gappy valid
        wr_cnt = 0; bl_cnt = 0;
        run_load(1'b1, -2, 0, 1'b0, -1, -1);
        wait_done();
        chk("l2_done", done, 1);
        chk("l2_det_en", det_en, 1);
        chk("l2_writes", wr_cnt, 36);
        chk("l2_bloads", bl_cnt, 1);
        $display("load gappy: writes %0d bias_loads %0d done %0b err %0b", wr_cnt, bl_cnt, done, err);

        // Early s_last on word 10 beat 5
        wr_cnt = 0; bl_cnt = 0;
        run_load(1'b0, 10, 5, 1'b0, -1, -1);
        repeat (50) @(posedge clk);
        #1 chk("e1_err", err, 1);
        chk("e1_done", done, 0);
        chk("e1_busy", busy, 0);
        chk("e1_det_en", det_en, 0);
        chk("e1_writes", wr_cnt, 10);
        chk("e1_last_addr", last_addr, 9);
        $display("load early_last: writes %0d done %0b err %0b", wr_cnt, done, err);

        // s_last on the bias beat
        wr_cnt = 0; bl_cnt = 0;
        run_load(1'b0, -1, 0, 1'b0, -1, -1);
        repeat (10) @(posedge clk);
        #1 chk("e2_err", err, 1);
        chk("e2_busy", busy, 0);
        chk("e2_bloads", bl_cnt, 0);
        chk("e2_writes", wr_cnt, 0);
        $display("load bias_last: writes %0d bias_loads %0d err %0b", wr_cnt, bl_cnt, err);

        // s_last missing on the final beat
        wr_cnt = 0; bl_cnt = 0;
        run_load(1'b0, -2, 0, 1'b1, -1, -1);
        repeat (10) @(posedge clk);
        #1 chk("e3_err", err, 1);
        chk("e3_done", done, 0);
        chk("e3_det_en", det_en, 0);
        chk("e3_writes", wr_cnt, 35);
        chk("e3_last_addr", last_addr, 34);
        $display("load missing_last: writes %0d done %0b err %0b", wr_cnt, done, err);

        // Ignored start at word 5, reset at word 20, then a fresh load
        wr_cnt = 0; bl_cnt = 0;
        run_load(1'b0, -2, 0, 1'b0, 5, 20);
        check_cleared("midrst");
        chk("midrst_writes", wr_cnt, 20);
        $display("load reset_mid: writes %0d", wr_cnt);
        wr_cnt = 0; bl_cnt = 0;
        run_load(1'b0, -2, 0, 1'b0, -1, -1);
        wait_done();
        chk("l3_done", done, 1);
        chk("l3_det_en", det_en, 1);
        chk("l3_writes", wr_cnt, 36);
        $display("load after_reset: writes %0d done %0b err %0b", wr_cnt, done, err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/svm_cfg_loader.md
SVM_CFG_LOADER -- requirements
Module: svm_cfg_loader

Interface
REQ-001 SHALL have parameter COEF_W, default 12, meaning SVM coefficient/bias width.
REQ-002 SHALL have parameter N_COEF, default 105, meaning coefficients per RAM word (15 rows x 7 cols).
REQ-003 SHALL have parameter ADDR_W, default 6, meaning coefficient RAM address width.
REQ-004 SHALL have parameter N_WORDS, default 36, meaning RAM words per model.
REQ-005 SHALL have parameter BUS_W, default 32, meaning load-stream width.
REQ-006 SHALL derive RAM_DW = COEF_W*N_COEF (1260) and BEATS = ceil(RAM_DW/BUS_W) (40).
REQ-007 SHALL have one clock; reset is synchronous and active-high.
REQ-008 clk  input  1  sole clock, all state on rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 start  input  1  one-cycle pulse that begins a model load.
REQ-011 s_valid  input  1  stream beat valid.
REQ-012 s_ready  output  1  stream beat accepted when s_valid & s_ready.
REQ-013 s_data  input  BUS_W  stream payload.
REQ-014 s_last  input  1  marks final beat of model.
REQ-015 addr_a  output  ADDR_W  coefficient RAM write address.
REQ-016 write_en  output  1  coefficient RAM write strobe.
REQ-017 i_data  output  RAM_DW  coefficient RAM write data.
REQ-018 bias  output  COEF_W  SVM bias value.
REQ-019 b_load  output  1  one-cycle bias load strobe.
REQ-020 busy  output  1  load in progress.
REQ-021 done  output  1  sticky: last load completed without error.
REQ-022 err  output  1  sticky: last load aborted on framing error.
REQ-023 det_en  output  1  detection enable for HOG/SVM pipeline; high only with valid model.

Function
REQ-024 SHALL implement FSM states IDLE, BIAS, FILL, WRITE; all outputs registered.
REQ-025 IDLE: s_ready=0, busy=0; start=1 -> BIAS next cycle, busy=1, done=0, err=0, det_en=0.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 BIAS: s_ready=1; on handshake bias<=s_data[COEF_W-1:0], b_load=1 the next cycle only, word=0, beat=0, -> FILL.
REQ-028 FILL: s_ready=1; beat k handshake writes s_data into buffer bits [BUS_W*k +: BUS_W], bits at or above RAM_DW discarded (beat 39 keeps 12 LSBs).
REQ-029 FILL: handshake with beat=BEATS-1 -> WRITE; else beat+1.
REQ-030 WRITE: s_ready=0; write_en=1 for exactly one cycle with addr_a=word, i_data=buffer; then word=N_WORDS-1 -> IDLE with done=1, det_en=1; else word+1, beat=0, -> FILL.
REQ-031 write_en SHALL assert the cycle after the final-beat handshake of each word; at most one write per word.
REQ-032 s_last=1 on any beat other than beat BEATS-1 of word N_WORDS-1, including bias beat -> IDLE, err=1, no write for current word.
REQ-033 s_last=0 on beat BEATS-1 of word N_WORDS-1 -> IDLE, err=1, word 35 not written.
REQ-034 s_valid=0 cycles SHALL stall without state change; no timeout.
REQ-035 Minimum load time with continuous s_valid: 1 bias beat + 36*(40+1) = 1477 cycles from BIAS entry to done.
REQ-036 addr_a/i_data SHALL hold last value when write_en=0.

Reset
REQ-037 rst=1 SHALL force IDLE and s_ready, write_en, b_load, busy, done, err, det_en, addr_a, bias, i_data to 0 next edge, overriding start and handshakes.
REQ-038 rst mid-load SHALL abandon load; RAM content undefined, det_en=0 until next successful load.

Verification
REQ-039 rst held 2 cycles -> all outputs 0, s_ready=0; start ignored while rst=1.
REQ-040 start, bias beat 0x0A5, 36x40 beats data={word[15:0],beat[15:0]}, continuous valid, s_last on final beat -> b_load one pulse bias=0x0A5, 36 write_en pulses addr 0..35 with matching i_data, done=1, det_en=1 after 1477 cycles.
REQ-041 Same load with s_valid randomly low 50% -> identical writes and bias; s_ready=0 in every WRITE cycle.
REQ-042 s_last on word 10 beat 5 -> err=1, done=0, busy=0, last write addr 9, no further write_en.
REQ-043 s_last omitted on final beat -> err=1, 35 writes (addr 0..34), det_en=0.
REQ-044 start pulsed at word 5 (ignored, load completes); rst at word 20, then new start -> writes restart at addr 0, done=1.
